nios2os_avalon_st_err_drop_fifo: RTL and testbench
==================================================

Name: nios2os_avalon_st_err_drop_fifo

Overview:
- Store-and-forward packet FIFO placed directly downstream of the Avalon-ST error adapter in the webserver datapath; consumes its 32-bit sop/eop/empty/error stream.
- Buffers each packet whole and releases it downstream only after its eop arrives with no error flagged on any beat.
- Errored, truncated and oversize packets are discarded silently and counted, so the MAC/DMA consumer sees only clean, complete packets.

Parameters:
- DEPTH, 64, entries in packet buffer; power of 2, >= 4.
- ADDR_W, 6, log2(DEPTH); pointers are ADDR_W+1 bits (wrap bit).
- CNT_W, 16, width of drop/pass counters.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- in_ready  out  1  sink ready.
- in_valid  in  1  sink valid.
- in_data  in  32  sink data.
- in_startofpacket  in  1  sink sop.
- in_endofpacket  in  1  sink eop.
- in_empty  in  2  sink empty bytes (eop beat only).
- in_error  in  1  sink error, any beat.
- out_ready  in  1  source ready.
- out_valid  out  1  source valid.
- out_data  out  32  source data.
- out_startofpacket  out  1  source sop.
- out_endofpacket  out  1  source eop.
- out_empty  out  2  source empty.
- drop_count  out  CNT_W  packets discarded, saturating.
- pass_count  out  CNT_W  packets committed, saturating.

Behaviour:
- Storage: DEPTH x 36 bits {sop, eop, empty, data}. Error is not stored.
- Pointers: wr_ptr (speculative), cm_ptr (committed), rd_ptr. used = wr_ptr - rd_ptr; full when used == DEPTH.
- Reset: all pointers 0, state IDLE, counters 0, out_valid 0, in_ready 0 while reset is asserted and 1 from the first cycle after release.
- Beat accept: in_valid & in_ready.
- in_ready = (state == DROP) | ~full.
- State machine: IDLE, PKT, DROP.
  - IDLE: accepted beat without sop is discarded, not counted. Accepted sop is written, err_sticky = in_error, then -> PKT; if sop & eop on the same beat, resolve per eop rules and stay IDLE.
  - PKT: each accepted beat is written; err_sticky |= in_error.
    - eop with err_sticky/in_error clear: cm_ptr <= wr_ptr+1, pass_count++, -> IDLE.
    - eop with error: wr_ptr <= cm_ptr, drop_count++, -> IDLE.
    - sop arriving in PKT (missing eop): rewind wr_ptr to cm_ptr, drop_count++, write the new sop at cm_ptr, restart err_sticky, stay PKT.
    - full in PKT with cm_ptr == rd_ptr (oversize, nothing left to drain): rewind wr_ptr to cm_ptr, drop_count++, -> DROP.
    - full with committed data pending: stall (in_ready = 0) until the reader frees space.
  - DROP: in_ready = 1; beats are discarded. eop -> IDLE. sop -> treat as a fresh IDLE sop in the same cycle.
- Read side: out_valid = (rd_ptr != cm_ptr). out_* come combinationally from mem[rd_ptr], show-ahead, 0-cycle read latency. rd_ptr increments on out_valid & out_ready.
- Latency: first beat of a packet is visible the cycle after its eop commits (cm_ptr is registered). Minimum in->out latency = packet length + 1 cycle.
- Simultaneous events: commit and read in the same cycle are both honoured. A rewind never moves below rd_ptr, since rd_ptr <= cm_ptr always.
- Pointer wrap is modulo 2^(ADDR_W+1); the full/empty distinction uses the MSB.
- Counters stick at all-ones.
- Reset mid-packet: all buffered data, including committed packets, is lost; no counter increments.
- out_valid is never retracted before out_ready. out_* are stable while stalled.

Decomposition:
- Package nios2os_st_pkg: beat record typedef {sop, eop, empty[1:0], data[31:0]}, state enum {IDLE, PKT, DROP}, BEAT_W = 36 constant.
- One sub-module: nios2os_st_ram, a simple dual-port register array (DEPTH x BEAT_W, sync write, async read). Control and the state machine stay in the top module.

Test Plan:
- 3 clean packets of 4, 1 (sop+eop) and 10 beats, out_ready = 1 -> identical beats out in order; pass_count = 3, drop_count = 0; first out beat appears 1 cycle after each eop.
- 5-beat packet with in_error on beat 3, followed by a clean 2-beat packet -> only the 2-beat packet is output; drop_count = 1; wr_ptr rewound, so the occupancy check shows 0 entries before the second packet.
- DEPTH = 8, 12-beat clean packet -> enters DROP when 8 beats are buffered, in_ready stays 1, nothing output, drop_count = 1; the next 3-beat packet passes.
- sop, 2 beats, then a new sop without eop, then a 3-beat clean packet -> only the 3-beat packet is output; drop_count = 1.
- out_ready toggled 1010… while 4 back-to-back 6-beat packets stream with DEPTH = 16 -> no loss or duplication, in_ready deasserts only when full, out_* stable while stalled.
- Assert reset for 1 cycle mid-packet with 1 committed packet pending -> out_valid = 0 the next cycle, counters = 0; a subsequent clean packet passes normally.

Source files
------------

// File: rtl/nios2os_st_pkg.sv
// Shared types for the Avalon-ST error-drop packet FIFO.
// A beat is stored as {sop, eop, empty, data}; the error flag is resolved at eop and never stored.
package nios2os_st_pkg;

  localparam int BEAT_W = 36;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic [31:0] data;
  } beat_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } state_e;

endpackage

// File: rtl/nios2os_st_ram.sv
// Simple dual-port beat store: synchronous write, asynchronous (show-ahead) read.
module nios2os_st_ram
  import nios2os_st_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  beat_t             wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output beat_t             rdata_o
);

  beat_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/nios2os_avalon_st_err_drop_fifo.sv
// Store-and-forward packet FIFO: a packet becomes visible only after a clean eop;
// errored, truncated (missing eop) and oversize packets are rewound away and counted.
module nios2os_avalon_st_err_drop_fifo
  import nios2os_st_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              in_ready,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_startofpacket,
  input  logic              in_endofpacket,
  input  logic [1:0]        in_empty,
  input  logic              in_error,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [31:0]       out_data,
  output logic              out_startofpacket,
  output logic              out_endofpacket,
  output logic [1:0]        out_empty,
  output logic [CNT_W-1:0]  drop_count,
  output logic [CNT_W-1:0]  pass_count,
  output state_e            dbg_state,
  output logic [ADDR_W:0]   dbg_used
);

  // Handshake on both sides: a beat moves on a clock edge where valid & ready are both high;
  // valid never depends on ready, and a presented source beat holds until it is taken.

  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]  cm_ptr_q, cm_ptr_d;
  logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]  used;
  logic [ADDR_W:0]  waddr;
  state_e           state_q, state_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W:0]   drop_sum, pass_sum;
  logic [1:0]       drop_n;
  logic             pass_n;
  logic             full, accept, rd_fire, we, start;
  beat_t            wbeat, rbeat;

  assign used      = wr_ptr_q - rd_ptr_q;
  assign full      = (used == DEPTH_P);
  assign in_ready  = ~reset & ((state_q == DROP) | ~full);
  assign accept    = in_valid & in_ready;
  assign out_valid = (rd_ptr_q != cm_ptr_q);
  assign rd_fire   = out_valid & out_ready;
  assign wbeat     = {in_startofpacket, in_endofpacket, in_empty, in_data};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    cm_ptr_d = cm_ptr_q;
    state_d  = state_q;
    err_d    = err_q;
    we       = 1'b0;
    waddr    = wr_ptr_q;
    drop_n   = 2'd0;
    pass_n   = 1'b0;
    start    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept && in_startofpacket) start = 1'b1;
      end
      PKT: begin
        if (accept) begin
          if (in_startofpacket) begin
            // Previous packet never saw its eop: discard it and restart at the commit point.
            drop_n = 2'd1;
            start  = 1'b1;
          end else begin
            we = 1'b1;
            if (in_endofpacket) begin
              state_d = IDLE;
              if (err_q | in_error) begin
                wr_ptr_d = cm_ptr_q;
                drop_n   = 2'd1;
              end else begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                cm_ptr_d = wr_ptr_q + 1'b1;
                pass_n   = 1'b1;
              end
            end else begin
              wr_ptr_d = wr_ptr_q + 1'b1;
              err_d    = err_q | in_error;
            end
          end
        end else if (full && (cm_ptr_q == rd_ptr_q)) begin
          // The packet alone fills the buffer and nothing can drain: it can never commit.
          wr_ptr_d = cm_ptr_q;
          drop_n   = 2'd1;
          state_d  = DROP;
        end
      end
      DROP: begin
        if (accept) begin
          if (in_startofpacket) start = 1'b1;
          else if (in_endofpacket) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      we    = 1'b1;
      waddr = cm_ptr_q;
      if (in_endofpacket) begin
        state_d = IDLE;
        if (in_error) begin
          wr_ptr_d = cm_ptr_q;
          drop_n   = drop_n + 2'd1;
        end else begin
          wr_ptr_d = cm_ptr_q + 1'b1;
          cm_ptr_d = cm_ptr_q + 1'b1;
          pass_n   = 1'b1;
        end
      end else begin
        wr_ptr_d = cm_ptr_q + 1'b1;
        err_d    = in_error;
        state_d  = PKT;
      end
    end
  end

  assign rd_ptr_d   = rd_ptr_q + {{ADDR_W{1'b0}}, rd_fire};
  assign drop_sum   = {1'b0, drop_cnt_q} + {{(CNT_W-1){1'b0}}, drop_n};
  assign pass_sum   = {1'b0, pass_cnt_q} + {{CNT_W{1'b0}}, pass_n};
  assign drop_cnt_d = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
  assign pass_cnt_d = pass_sum[CNT_W] ? {CNT_W{1'b1}} : pass_sum[CNT_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      cm_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= IDLE;
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
      pass_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      cm_ptr_q   <= cm_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

  nios2os_st_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr[ADDR_W-1:0]),
    .wdata_i (wbeat),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (rbeat)
  );

  assign out_data          = rbeat.data;
  assign out_startofpacket = rbeat.sop;
  assign out_endofpacket   = rbeat.eop;
  assign out_empty         = rbeat.empty;
  assign drop_count        = drop_cnt_q;
  assign pass_count        = pass_cnt_q;
  assign dbg_state         = state_q;
  assign dbg_used          = used;

endmodule

// File: tb/tb_nios2os_avalon_st_err_drop_fifo.sv
// Directed bench for the error-drop packet FIFO (DEPTH = 16) with an expected-beat queue.
module tb_nios2os_avalon_st_err_drop_fifo;
  import nios2os_st_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 16;

  logic              clk, reset;
  logic              in_ready, in_valid, in_startofpacket, in_endofpacket, in_error;
  logic [31:0]       in_data;
  logic [1:0]        in_empty;
  logic              out_ready, out_valid, out_startofpacket, out_endofpacket;
  logic [31:0]       out_data;
  logic [1:0]        out_empty;
  logic [CNT_W-1:0]  drop_count, pass_count;
  state_e            dbg_state;
  logic [ADDR_W:0]   dbg_used;

  int n_checks, n_errors;
  logic [BEAT_W-1:0] exp_q[$];
  logic [BEAT_W-1:0] obs_beat;

  assign obs_beat = {out_startofpacket, out_endofpacket, out_empty, out_data};

  nios2os_avalon_st_err_drop_fifo #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .in_empty(in_empty), .in_error(in_error),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
    .out_empty(out_empty), .drop_count(drop_count), .pass_count(pass_count),
    .dbg_state(dbg_state), .dbg_used(dbg_used)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [31:0] d, input bit sop, input bit eop,
                           input logic [1:0] emp, input bit err);
    bit acc;
    in_valid = 1'b1; in_data = d; in_startofpacket = sop;
    in_endofpacket = eop; in_empty = emp; in_error = err;
    acc = 1'b0;
    for (int t = 0; t < 300 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    if (!acc) begin
      n_checks++; n_errors++;
      $display("FAIL accept_timeout: in_ready=%0b required 1 within 300 cycles", in_ready);
    end
    in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0; in_error = 1'b0;
  endtask

  task automatic send_pkt(input int id, input int len, input int err_beat, input bit pass);
    logic [31:0] d;
    logic [1:0]  emp;
    bit          sop, eop;
    for (int i = 0; i < len; i++) begin
      d   = {id[7:0], 8'h5A, 16'(i)};
      sop = (i == 0);
      eop = (i == len - 1);
      emp = eop ? id[1:0] : 2'd0;
      if (pass) exp_q.push_back({sop, eop, emp, d});
      send_beat(d, sop, eop, emp, (i == err_beat));
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    @(posedge clk); #1;
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL drain_timeout: %0d beats outstanding, out_valid=%0b required 0 and 0",
               exp_q.size(), out_valid);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic scoreboard();
    bit prev_stall;
    logic [BEAT_W-1:0] prev_beat, exp_b;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          n_checks++;
          if (!out_valid || obs_beat !== prev_beat) begin
            n_errors++;
            $display("FAIL stall_hold: valid=%0b beat=%h required valid=1 beat=%h",
                     out_valid, obs_beat, prev_beat);
          end
        end
        if (out_valid && out_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_beat: got %h required no beat", obs_beat);
          end else begin
            exp_b = exp_q.pop_front();
            if (obs_beat !== exp_b) begin
              n_errors++;
              $display("FAIL out_beat: got %h required %h", obs_beat, exp_b);
            end
          end
        end
        if (!in_ready && dbg_state != DROP) begin
          n_checks++;
          if (dbg_used !== 5'd16) begin
            n_errors++;
            $display("FAIL ready_low_not_full: used=%0d required 16", dbg_used);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_beat  = obs_beat;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL rst_in_ready: got %0b required 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_out_valid: got %0b required 0", out_valid); end
    n_checks++; if (drop_count !== 16'd0 || pass_count !== 16'd0) begin n_errors++; $display("FAIL rst_counts: drop=%0d pass=%0d required 0 0", drop_count, pass_count); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rel_in_ready: got %0b required 1", in_ready); end
    n_checks++; if (dbg_state !== IDLE || dbg_used !== 5'd0) begin n_errors++; $display("FAIL rel_state: state=%0d used=%0d required 0 0", dbg_state, dbg_used); end
  endtask

  task automatic test_clean();
    int lens[3];
    logic [31:0] d;
    logic [1:0]  emp;
    lens = '{4, 1, 10};
    out_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < lens[p]; i++) begin
        d   = {8'(p + 1), 8'h5A, 16'(i)};
        emp = (i == lens[p] - 1) ? 2'(p + 1) : 2'd0;
        exp_q.push_back({(i == 0), (i == lens[p] - 1), emp, d});
        if (i == lens[p] - 1) begin
          n_checks++;
          if (out_valid !== 1'b0) begin n_errors++; $display("FAIL lat_pre pkt%0d: out_valid=%0b required 0", p, out_valid); end
        end
        send_beat(d, (i == 0), (i == lens[p] - 1), emp, 1'b0);
      end
      n_checks++;
      if (out_valid !== 1'b1 || out_startofpacket !== 1'b1) begin
        n_errors++;
        $display("FAIL lat_post pkt%0d: valid=%0b sop=%0b required 1 1", p, out_valid, out_startofpacket);
      end
      wait_drain();
    end
    n_checks++;
    if (pass_count !== 16'd3 || drop_count !== 16'd0) begin
      n_errors++; $display("FAIL clean_counts: pass=%0d drop=%0d required 3 0", pass_count, drop_count);
    end
  endtask

  task automatic test_error();
    out_ready = 1'b1;
    send_pkt(10, 5, 2, 1'b0);
    n_checks++;
    if (dbg_used !== 5'd0 || out_valid !== 1'b0 || dbg_state !== IDLE) begin
      n_errors++; $display("FAIL err_rewind: used=%0d valid=%0b state=%0d required 0 0 0", dbg_used, out_valid, dbg_state);
    end
    n_checks++;
    if (drop_count !== 16'd1) begin n_errors++; $display("FAIL err_drop: got %0d required 1", drop_count); end
    send_pkt(11, 2, -1, 1'b1);
    wait_drain();
    n_checks++;
    if (pass_count !== 16'd4) begin n_errors++; $display("FAIL err_pass: got %0d required 4", pass_count); end
  endtask

  task automatic test_oversize();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send_beat({8'h20, 8'h5A, 16'(i)}, (i == 0), (i == 19), 2'd0, 1'b0);
      if (i == 15) begin
        n_checks++;
        if (dbg_used !== 5'd16 || dbg_state !== PKT || in_ready !== 1'b0) begin
          n_errors++; $display("FAIL ovs_full: used=%0d state=%0d rdy=%0b required 16 1 0", dbg_used, dbg_state, in_ready);
        end
      end
      if (i == 16) begin
        n_checks++;
        if (dbg_state !== DROP || dbg_used !== 5'd0 || in_ready !== 1'b1) begin
          n_errors++; $display("FAIL ovs_drop_state: state=%0d used=%0d rdy=%0b required 2 0 1", dbg_state, dbg_used, in_ready);
        end
      end
    end
    n_checks++;
    if (drop_count !== 16'd2 || dbg_state !== IDLE || out_valid !== 1'b0) begin
      n_errors++; $display("FAIL ovs_end: drop=%0d state=%0d valid=%0b required 2 0 0", drop_count, dbg_state, out_valid);
    end
    send_pkt(21, 3, -1, 1'b1);
    wait_drain();
    n_checks++;
    if (pass_count !== 16'd5) begin n_errors++; $display("FAIL ovs_pass: got %0d required 5", pass_count); end
  endtask

  task automatic test_missing_eop();
    out_ready = 1'b1;
    send_beat({8'h30, 8'h5A, 16'd0}, 1'b1, 1'b0, 2'd0, 1'b0);
    send_beat({8'h30, 8'h5A, 16'd1}, 1'b0, 1'b0, 2'd0, 1'b0);
    send_pkt(31, 3, -1, 1'b1);
    wait_drain();
    n_checks++;
    if (drop_count !== 16'd3 || pass_count !== 16'd6) begin
      n_errors++; $display("FAIL noeop_counts: drop=%0d pass=%0d required 3 6", drop_count, pass_count);
    end
  endtask

  task automatic test_back_to_back();
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    fork
      begin
        for (int p = 0; p < 4; p++) send_pkt(40 + p, 6, -1, 1'b1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ~out_ready;
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    n_checks++;
    if (pass_count !== 16'd10 || drop_count !== 16'd3) begin
      n_errors++; $display("FAIL b2b_counts: pass=%0d drop=%0d required 10 3", pass_count, drop_count);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send_pkt(50, 2, -1, 1'b1);
    send_beat({8'h51, 8'h5A, 16'd0}, 1'b1, 1'b0, 2'd0, 1'b0);
    send_beat({8'h51, 8'h5A, 16'd1}, 1'b0, 1'b0, 2'd0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1) begin n_errors++; $display("FAIL mid_pending: valid=%0b required 1", out_valid); end
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || dbg_used !== 5'd0 || dbg_state !== IDLE) begin
      n_errors++; $display("FAIL mid_flush: valid=%0b used=%0d state=%0d required 0 0 0", out_valid, dbg_used, dbg_state);
    end
    n_checks++;
    if (drop_count !== 16'd0 || pass_count !== 16'd0) begin
      n_errors++; $display("FAIL mid_counts: drop=%0d pass=%0d required 0 0", drop_count, pass_count);
    end
    out_ready = 1'b1;
    send_pkt(52, 3, -1, 1'b1);
    wait_drain();
    n_checks++;
    if (pass_count !== 16'd1 || drop_count !== 16'd0) begin
      n_errors++; $display("FAIL mid_after: pass=%0d drop=%0d required 1 0", pass_count, drop_count);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0; n_errors = 0;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_startofpacket = 1'b0;
    in_endofpacket = 1'b0; in_empty = '0; in_error = 1'b0; out_ready = 1'b0;
    fork
      scoreboard();
      begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none
    test_reset();
    test_clean();
    test_error();
    test_oversize();
    test_missing_eop();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
